multicycle_controller: RTL and testbench

Control FSM for the multicycle MIPS32 core. It sequences one shared ALU, one unified instruction/data memory port and the register file across several clock cycles per instruction. It replaces the single-cycle control path and drives every mux select and write enable in the datapath. It stalls on a memory-ready handshake, so wait-state memories are supported.

---
 rtl/mips_ctrl_pkg.sv | 60 ++++++
 rtl/multicycle_controller_ctrl_out_decode.sv | 102 ++++++++++
 rtl/multicycle_controller.sv | 120 ++++++++++++
 tb/tb_multicycle_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS32 control path: FSM state
// encodings, opcode constants and the select/op encodings driven onto the
// datapath.  Imported by the controller, the ALU decoder and the datapath so
// all three agree on every code point.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

   localparam int OPCODE_W = 6;
   localparam int STATE_W  = 4;

   typedef logic [STATE_W-1:0]  state_t;
   typedef logic [OPCODE_W-1:0] opcode_t;

   // FSM states (4-bit, fixed encoding; 12..15 unused)
   localparam logic [3:0] ST_FETCH  = 4'd0;
   localparam logic [3:0] ST_DECODE = 4'd1;
   localparam logic [3:0] ST_MEMADR = 4'd2;
   localparam logic [3:0] ST_MEMRD  = 4'd3;
   localparam logic [3:0] ST_MEMWB  = 4'd4;
   localparam logic [3:0] ST_MEMWR  = 4'd5;
   localparam logic [3:0] ST_EXEC   = 4'd6;
   localparam logic [3:0] ST_ALUWB  = 4'd7;
   localparam logic [3:0] ST_BRANCH = 4'd8;
   localparam logic [3:0] ST_ADDIEX = 4'd9;
   localparam logic [3:0] ST_ADDIWB = 4'd10;
   localparam logic [3:0] ST_JUMP   = 4'd11;

   // Supported opcodes (instr[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // aluOp encodings
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // aluSrcB encodings
   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   // pcSrc encodings
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // True for every opcode the controller knows how to sequence.
   function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/multicycle_controller_ctrl_out_decode.sv
// -----------------------------------------------------------------------------
// ctrl_out_decode
// Pure combinational decode from FSM state to datapath control signals.
// Every output defaults to 0 and only the signals a state needs are raised.
//
// Ports:
//   state      in  4  current FSM state
//   mem_ready  in  1  memory handshake (only consulted in FETCH)
//   zero       in  1  ALU zero flag (only consulted in BRANCH)
//   mem_req, memWrite, iorD, irWrite, pcEn, pcSrc, regWrite, regDest,
//   memtoReg, aluSrcA, aluSrcB, aluOp   out  datapath controls
// -----------------------------------------------------------------------------
module ctrl_out_decode
   import mips_ctrl_pkg::*;
(
   input  logic [3:0] state,
   input  logic       mem_ready,
   input  logic       zero,
   output logic       mem_req,
   output logic       memWrite,
   output logic       iorD,
   output logic       irWrite,
   output logic       pcEn,
   output logic [1:0] pcSrc,
   output logic       regWrite,
   output logic       regDest,
   output logic       memtoReg,
   output logic       aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] aluOp
);

   always_comb begin
      mem_req  = 1'b0;
      memWrite = 1'b0;
      iorD     = 1'b0;
      irWrite  = 1'b0;
      pcEn     = 1'b0;
      pcSrc    = PCSRC_ALU;
      regWrite = 1'b0;
      regDest  = 1'b0;
      memtoReg = 1'b0;
      aluSrcA  = 1'b0;
      aluSrcB  = SRCB_REG;
      aluOp    = ALUOP_ADD;

      case (state)
         ST_FETCH: begin
            // PC+4 is computed every fetch cycle, but IR and PC only load
            // on the cycle the memory actually returns the instruction.
            mem_req = 1'b1;
            aluSrcB = SRCB_FOUR;
            irWrite = mem_ready;
            pcEn    = mem_ready;
         end
         ST_DECODE: begin
            // Branch target precomputed into ALUOut while registers are read.
            aluSrcB = SRCB_IMMSH2;
         end
         ST_MEMADR, ST_ADDIEX: begin
            aluSrcA = 1'b1;
            aluSrcB = SRCB_IMM;
         end
         ST_MEMRD: begin
            mem_req = 1'b1;
            iorD    = 1'b1;
         end
         ST_MEMWR: begin
            mem_req  = 1'b1;
            iorD     = 1'b1;
            memWrite = 1'b1;
         end
         ST_MEMWB: begin
            regWrite = 1'b1;
            memtoReg = 1'b1;
         end
         ST_EXEC: begin
            aluSrcA = 1'b1;
            aluOp   = ALUOP_FUNCT;
         end
         ST_ALUWB: begin
            regWrite = 1'b1;
            regDest  = 1'b1;
         end
         ST_ADDIWB: begin
            regWrite = 1'b1;
         end
         ST_BRANCH: begin
            aluSrcA = 1'b1;
            aluOp   = ALUOP_SUB;
            pcSrc   = PCSRC_ALUOUT;
            pcEn    = zero;
         end
         ST_JUMP: begin
            pcSrc = PCSRC_JUMP;
            pcEn  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for the multicycle MIPS32 core.  Holds the state register and
// next-state logic; the per-state control values come from ctrl_out_decode.
// Memory accesses stall in FETCH / MEMRD / MEMWR until mem_ready.
//
// Ports:
//   clk        in   1     rising-edge clock
//   rst_n      in   1     synchronous active-low reset
//   opcode     in   OP_W  instr[31:26] from the instruction register
//   zero       in   1     ALU zero flag
//   mem_ready  in   1     memory completes the current access this cycle
//   mem_req .. aluOp out  datapath controls (all 0 while rst_n is low)
//   illegal_op out  1     one-cycle pulse on an unsupported opcode in DECODE
// -----------------------------------------------------------------------------
module multicycle_controller
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] opcode,
   input  logic            zero,
   input  logic            mem_ready,
   output logic            mem_req,
   output logic            memWrite,
   output logic            iorD,
   output logic            irWrite,
   output logic            pcEn,
   output logic [1:0]      pcSrc,
   output logic            regWrite,
   output logic            regDest,
   output logic            memtoReg,
   output logic            aluSrcA,
   output logic [1:0]      aluSrcB,
   output logic [1:0]      aluOp,
   output logic            illegal_op
);

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic       op_legal;

   logic       d_mem_req, d_memWrite, d_iorD, d_irWrite, d_pcEn;
   logic       d_regWrite, d_regDest, d_memtoReg, d_aluSrcA;
   logic [1:0] d_pcSrc, d_aluSrcB, d_aluOp;

   assign op_legal = is_legal_op(opcode);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = ST_FETCH;
      case (state)
         ST_FETCH:  state_nxt = mem_ready ? ST_DECODE : ST_FETCH;
         ST_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_nxt = ST_MEMADR;
               OP_RTYPE:     state_nxt = ST_EXEC;
               OP_BEQ:       state_nxt = ST_BRANCH;
               OP_ADDI:      state_nxt = ST_ADDIEX;
               OP_J:         state_nxt = ST_JUMP;
               default:      state_nxt = ST_FETCH;
            endcase
         end
         ST_MEMADR: begin
            // Only lw/sw reach here; anything else is treated as an abort.
            if (opcode == OP_LW)      state_nxt = ST_MEMRD;
            else if (opcode == OP_SW) state_nxt = ST_MEMWR;
            else                      state_nxt = ST_FETCH;
         end
         ST_MEMRD:  state_nxt = mem_ready ? ST_MEMWB : ST_MEMRD;
         ST_MEMWR:  state_nxt = mem_ready ? ST_FETCH : ST_MEMWR;
         ST_EXEC:   state_nxt = ST_ALUWB;
         ST_ADDIEX: state_nxt = ST_ADDIWB;
         // MEMWB, ALUWB, ADDIWB, BRANCH, JUMP and the unused codes 12..15
         default:   state_nxt = ST_FETCH;
      endcase
   end

   ctrl_out_decode u_dec (
      .state     (state),
      .mem_ready (mem_ready),
      .zero      (zero),
      .mem_req   (d_mem_req),
      .memWrite  (d_memWrite),
      .iorD      (d_iorD),
      .irWrite   (d_irWrite),
      .pcEn      (d_pcEn),
      .pcSrc     (d_pcSrc),
      .regWrite  (d_regWrite),
      .regDest   (d_regDest),
      .memtoReg  (d_memtoReg),
      .aluSrcA   (d_aluSrcA),
      .aluSrcB   (d_aluSrcB),
      .aluOp     (d_aluOp)
   );

   // The state register only clears on the reset edge, so outputs are gated
   // here to keep every enable and select low for the whole reset cycle.
   assign mem_req    = rst_n & d_mem_req;
   assign memWrite   = rst_n & d_memWrite;
   assign iorD       = rst_n & d_iorD;
   assign irWrite    = rst_n & d_irWrite;
   assign pcEn       = rst_n & d_pcEn;
   assign regWrite   = rst_n & d_regWrite;
   assign regDest    = rst_n & d_regDest;
   assign memtoReg   = rst_n & d_memtoReg;
   assign aluSrcA    = rst_n & d_aluSrcA;
   assign pcSrc      = rst_n ? d_pcSrc   : 2'b00;
   assign aluSrcB    = rst_n ? d_aluSrcB : 2'b00;
   assign aluOp      = rst_n ? d_aluOp   : 2'b00;
   assign illegal_op = rst_n & (state == ST_DECODE) & ~op_legal;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, memWrite, iorD, irWrite, pcEn, regWrite, regDest;
   logic       memtoReg, aluSrcA, illegal_op;
   logic [1:0] pcSrc, aluSrcB, aluOp;

   multicycle_controller #(.OP_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .memWrite(memWrite),
      .iorD(iorD), .irWrite(irWrite), .pcEn(pcEn), .pcSrc(pcSrc),
      .regWrite(regWrite), .regDest(regDest), .memtoReg(memtoReg),
      .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
   localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

   int n_assert = 0;
   int n_fail   = 0;

   // One expected clock cycle: inputs to apply and the full control word.
   typedef struct packed {
      logic [5:0]  op;
      logic        mr;
      logic        zr;
      logic [15:0] ex;
   } step_t;

   step_t q[$];

   logic [15:0] obs;
   assign obs = {mem_req, memWrite, iorD, irWrite, pcEn, pcSrc, regWrite,
                 regDest, memtoReg, aluSrcA, aluSrcB, aluOp, illegal_op};

   function automatic logic [15:0] cw(input logic req, mw, iord, irw, pcen,
                                      input logic [1:0] pcs,
                                      input logic rw, rd, m2r, asa,
                                      input logic [1:0] asb, aop,
                                      input logic ill);
      return {req, mw, iord, irw, pcen, pcs, rw, rd, m2r, asa, asb, aop, ill};
   endfunction

   function automatic bit legal(input logic [5:0] op);
      return op inside {RT, LW, SW, BEQ, ADDI, JMP};
   endfunction

   task automatic push(input logic [5:0] op, input logic mr, input logic zr,
                       input logic [15:0] ex);
      q.push_back('{op: op, mr: mr, zr: zr, ex: ex});
   endtask

   // Expected cycle list for one instruction: fw fetch wait cycles, mw data
   // memory wait cycles, z the zero flag seen in a branch.
   task automatic add_instr(input logic [5:0] op, input int fw, input int mw,
                            input logic z);
      logic [5:0] junk;
      for (int i = 0; i <= fw; i++) begin
         junk = 6'($urandom);   // IR still holds the previous instruction
         push(junk, i == fw, 1'($urandom),
              cw(1, 0, 0, i == fw, i == fw, 2'b00, 0, 0, 0, 0, 2'b01, 2'b00, 0));
      end
      push(op, 1'($urandom), 1'($urandom),
           cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 2'b11, 2'b00, !legal(op)));
      case (op)
         LW, SW: begin
            push(op, 1'($urandom), 1'($urandom),
                 cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 2'b00, 0));
            for (int i = 0; i <= mw; i++)
               push(op, i == mw, 1'($urandom),
                    cw(1, op == SW, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));
            if (op == LW)
               push(op, 1'($urandom), 1'($urandom),
                    cw(0, 0, 0, 0, 0, 2'b00, 1, 0, 1, 0, 2'b00, 2'b00, 0));
         end
         RT: begin
            push(op, 1'($urandom), 1'($urandom),
                 cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b00, 2'b10, 0));
            push(op, 1'($urandom), 1'($urandom),
                 cw(0, 0, 0, 0, 0, 2'b00, 1, 1, 0, 0, 2'b00, 2'b00, 0));
         end
         ADDI: begin
            push(op, 1'($urandom), 1'($urandom),
                 cw(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 2'b10, 2'b00, 0));
            push(op, 1'($urandom), 1'($urandom),
                 cw(0, 0, 0, 0, 0, 2'b00, 1, 0, 0, 0, 2'b00, 2'b00, 0));
         end
         BEQ:
            push(op, 1'($urandom), z,
                 cw(0, 0, 0, 0, z, 2'b01, 0, 0, 0, 1, 2'b00, 2'b01, 0));
         JMP:
            push(op, 1'($urandom), 1'($urandom),
                 cw(0, 0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 2'b00, 2'b00, 0));
         default: ;
      endcase
   endtask

   task automatic check(input string tag, input int idx, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s step %0d: observed=%b expected=%b", tag, idx, obs, exp);
      end
   endtask

   // Called 1 time unit after a rising edge; leaves the same alignment.
   task automatic run_q(input string tag);
      step_t s;
      int idx = 0;
      while (q.size() > 0) begin
         s = q.pop_front();
         opcode    = s.op;
         mem_ready = s.mr;
         zero      = s.zr;
         #1;
         check(tag, idx, s.ex);
         idx++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [5:0] rop;
      int kind;

      rst_n = 1'b0; opcode = 6'b0; zero = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      check("reset_init", 0, 16'h0000);
      @(posedge clk); #1;
      check("reset_init", 1, 16'h0000);
      rst_n = 1'b1;

      add_instr(LW, 0, 0, 0);   run_q("lw");
      add_instr(SW, 0, 2, 0);   run_q("sw_wait");
      add_instr(BEQ, 0, 0, 1);  run_q("beq_taken");
      add_instr(BEQ, 0, 0, 0);  run_q("beq_not_taken");
      add_instr(RT, 0, 0, 0);
      add_instr(ADDI, 0, 0, 0); run_q("rtype_addi");
      add_instr(6'b111111, 0, 0, 0); run_q("illegal");
      add_instr(JMP, 2, 0, 0);  run_q("j_fetch_wait");
      add_instr(LW, 1, 3, 0);   run_q("lw_waits");

      // Reset while parked in a MEMWR wait, mem_ready high throughout.
      add_instr(SW, 0, 0, 0);
      void'(q.pop_back());   // drop the completing MEMWR cycle
      push(SW, 1'b0, 1'b0,
           cw(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 2'b00, 0));
      run_q("sw_pre_reset");
      rst_n = 1'b0; mem_ready = 1'b1; opcode = SW;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("reset_memwr", i, 16'h0000);
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      add_instr(ADDI, 0, 0, 0); run_q("after_reset");

      // Randomized instruction stream.
      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 6);
         case (kind)
            0: rop = RT;
            1: rop = LW;
            2: rop = SW;
            3: rop = BEQ;
            4: rop = ADDI;
            5: rop = JMP;
            default: begin
               rop = 6'($urandom);
               while (legal(rop)) rop = 6'($urandom);
            end
         endcase
         add_instr(rop, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
         run_q("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
